// File: rtl/zl_punct.sv
// Puncturer between the rate-1/2 convolutional encoder and the symbol mapper.
// Optional feature macro: ZL_PUNCT_HIGH_RATES_EN enables rates 5/6 and 7/8.
module zl_punct (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rate,
  input  logic       data_in_i,
  input  logic       data_in_q,
  input  logic       data_in_req,
  output logic       data_in_ack,
  output logic       data_out_i,
  output logic       data_out_q,
  output logic       data_out_req,
  input  logic       data_out_ack
);

`ifdef ZL_PUNCT_HIGH_RATES_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  logic [2:0]      rate_q;
  logic [2:0]      count_q, count_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [3:0]      bits_q, bits_d;

  logic       chg;
  logic       out_req;
  logic       pop;
  logic       push;
  logic [1:0] keep;
  logic [2:0] cnt_pop;
  logic       b0, b1, two;

  // Keep mask for the current phase as {keep X, keep Y}; bit n of a mask is position n+1.
  function automatic logic [1:0] keep_f(input logic [2:0] r, input logic [PH_W-1:0] ph);
    logic [7:0] xm;
    logic [7:0] ym;
    logic [2:0] idx;
    idx = 3'(ph);
    xm  = 8'hFF;
    ym  = 8'hFF;
    case (r)
      3'd1: begin xm = 8'b0000_0001; ym = 8'b0000_0011; end
      3'd2: begin xm = 8'b0000_0101; ym = 8'b0000_0011; end
`ifdef ZL_PUNCT_HIGH_RATES_EN
      3'd3: begin xm = 8'b0001_0101; ym = 8'b0000_1011; end
      3'd4: begin xm = 8'b0101_0001; ym = 8'b0010_1111; end
`endif
      default: begin xm = 8'hFF; ym = 8'hFF; end
    endcase
    return {xm[idx], ym[idx]};
  endfunction

  // Last phase of the puncturing period (period minus one).
  function automatic logic [PH_W-1:0] last_f(input logic [2:0] r);
    case (r)
      3'd1:    return PH_W'(1);
      3'd2:    return PH_W'(2);
`ifdef ZL_PUNCT_HIGH_RATES_EN
      3'd3:    return PH_W'(4);
      3'd4:    return PH_W'(6);
`endif
      default: return PH_W'(0);
    endcase
  endfunction

  assign chg          = (rate != rate_q);
  assign out_req      = !chg && (count_q >= 3'd2);
  assign pop          = out_req && data_out_ack;
  assign data_out_req = out_req;
  assign data_in_ack  = !chg && ((count_q <= 3'd2) || pop);
  assign push         = data_in_req && data_in_ack;
  assign keep         = keep_f(rate_q, phase_q);
  assign data_out_i   = bits_q[0];
  assign data_out_q   = bits_q[1];

  always_comb begin
    bits_d  = bits_q;
    count_d = count_q;
    phase_d = phase_q;
    cnt_pop = count_q;
    two     = (keep == 2'b11);
    b0      = keep[1] ? data_in_i : data_in_q;
    b1      = data_in_q;
    if (chg) begin
      bits_d  = '0;
      count_d = '0;
      phase_d = '0;
    end else begin
      // Pop first so a simultaneous push lands behind the remaining bits.
      if (pop) begin
        bits_d  = {2'b00, bits_q[3:2]};
        cnt_pop = count_q - 3'd2;
      end
      count_d = cnt_pop;
      if (push) begin
        for (int i = 0; i < 4; i++) begin
          if (3'(i) == cnt_pop) bits_d[i] = b0;
          if (two && (3'(i) == cnt_pop + 3'd1)) bits_d[i] = b1;
        end
        count_d = cnt_pop + (two ? 3'd2 : 3'd1);
        phase_d = (phase_q == last_f(rate_q)) ? '0 : phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q  <= '0;
      count_q <= '0;
      phase_q <= '0;
      bits_q  <= '0;
    end else begin
      rate_q  <= rate;
      count_q <= count_d;
      phase_q <= phase_d;
      bits_q  <= bits_d;
    end
  end

endmodule

// File: tb/tb_zl_punct.sv
// Scoreboard bench for zl_punct: directed pairs, expected symbol pairs queued by the stimulus.
module tb_zl_punct;

  logic       clk;
  logic       rst_n;
  logic [2:0] rate;
  logic       data_in_i, data_in_q, data_in_req;
  logic       data_in_ack;
  logic       data_out_i, data_out_q, data_out_req;
  logic       data_out_ack;

  int tests = 0;
  int fails = 0;
  logic [1:0] exp_q[$];

  zl_punct dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rate         (rate),
    .data_in_i    (data_in_i),
    .data_in_q    (data_in_q),
    .data_in_req  (data_in_req),
    .data_in_ack  (data_in_ack),
    .data_out_i   (data_out_i),
    .data_out_q   (data_out_q),
    .data_out_req (data_out_req),
    .data_out_ack (data_out_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every output transfer pops and compares one expected {I,Q}.
  always @(negedge clk) begin
    if (rst_n && data_out_req && data_out_ack) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got %b%b, expected no output", data_out_i, data_out_q);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({data_out_i, data_out_q} !== e) begin
          fails++;
          $display("FAIL out_pair: got %b%b, expected %b", data_out_i, data_out_q, e);
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that carried the transfer.
  task automatic send(input logic x, input logic y, output int stalls);
    data_in_i   = x;
    data_in_q   = y;
    data_in_req = 1'b1;
    stalls      = 0;
    @(negedge clk);
    while (!data_in_ack && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!data_in_ack) begin
      tests++;
      fails++;
      $display("FAIL in_ack_timeout: got no ack, expected ack within 50 cycles");
    end
    @(posedge clk);
    #1;
    data_in_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rate(input logic [2:0] r);
    rate = r;
    #1;
    chk("chg_in_ack", data_in_ack, 1'b0);
    chk("chg_out_req", data_out_req, 1'b0);
    @(posedge clk);
    #1;
    chk("post_chg_in_ack", data_in_ack, 1'b1);
    chk("post_chg_out_req", data_out_req, 1'b0);
  endtask

  logic x78 [14] = '{1,1,0,0,1,1,0, 0,0,1,1,0,0,1};
  logic y78 [14] = '{0,0,1,1,0,0,1, 1,1,0,0,1,1,0};
  logic [1:0] e78 [8] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11};

  initial begin
    int st;
    rst_n        = 1'b0;
    rate         = 3'd0;
    data_in_i    = 1'b0;
    data_in_q    = 1'b0;
    data_in_req  = 1'b0;
    data_out_ack = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_req", data_out_req, 1'b0);
    chk("rst_out_i", data_out_i, 1'b0);
    chk("rst_out_q", data_out_q, 1'b0);
    chk("rst_in_ack", data_in_ack, 1'b1);
    rst_n = 1'b1;
    idle(1);

    // Rate 1/2, continuous acks
    data_out_ack = 1'b1;
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    chk("r12_pre_req", data_out_req, 1'b0);
    send(1'b1, 1'b0, st);
    chk_int("r12_stall0", st, 0);
    chk("r12_latency_req", data_out_req, 1'b1);
    send(1'b0, 1'b1, st);
    chk_int("r12_stall1", st, 0);
    send(1'b1, 1'b1, st);
    chk_int("r12_stall2", st, 0);
    idle(3);
    chk_int("r12_drained", exp_q.size(), 0);

    // Rate 3/4: dropped bits are the complement of what a wrong pattern would pick
    set_rate(3'd2);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    send(1'b1, 1'b0, st); chk_int("r34_stall", st, 0);
    send(1'b1, 1'b0, st); chk_int("r34_stall", st, 0);
    send(1'b1, 1'b0, st); chk_int("r34_stall", st, 0);
    send(1'b0, 1'b1, st); chk_int("r34_stall", st, 0);
    send(1'b1, 1'b1, st); chk_int("r34_stall", st, 0);
    send(1'b0, 1'b1, st); chk_int("r34_stall", st, 0);
    idle(3);
    chk_int("r34_drained", exp_q.size(), 0);

    // Leave one bit buffered mid-period at 3/4, then switch to 7/8
    exp_q.push_back(2'b10);
    send(1'b1, 1'b0, st);
    send(1'b0, 1'b1, st);
    idle(3);
    chk_int("mid_drained", exp_q.size(), 0);
    chk("mid_req_low", data_out_req, 1'b0);
    set_rate(3'd4);
`ifdef ZL_PUNCT_HIGH_RATES_EN
    for (int k = 0; k < 8; k++) exp_q.push_back(e78[k]);
`else
    for (int k = 0; k < 14; k++) exp_q.push_back({x78[k], y78[k]});
`endif
    for (int k = 0; k < 14; k++) begin
      send(x78[k], y78[k], st);
      chk_int("r78_stall", st, 0);
    end
    idle(3);
    chk_int("r78_drained", exp_q.size(), 0);

    // Rate 2/3 with downstream stalled for 10 cycles at count 3
    data_out_ack = 1'b0;
    set_rate(3'd1);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b00);
    send(1'b1, 1'b1, st);
    chk_int("r23_stall_a", st, 0);
    send(1'b1, 1'b0, st);
    chk_int("r23_stall_b", st, 0);
    fork
      send(1'b0, 1'b1, st);
      begin
        repeat (10) begin
          @(negedge clk);
          chk("stall_in_ack", data_in_ack, 1'b0);
          chk("stall_out_req", data_out_req, 1'b1);
          chk("stall_out_i", data_out_i, 1'b1);
          chk("stall_out_q", data_out_q, 1'b1);
        end
        @(posedge clk);
        #1;
        data_out_ack = 1'b1;
      end
    join
    chk_int("r23_stall_cycles", st, 10);
    send(1'b1, 1'b1, st);
    chk_int("r23_stall_d", st, 0);
    send(1'b0, 1'b0, st);
    chk_int("r23_stall_e", st, 0);
    idle(4);
    chk_int("r23_drained", exp_q.size(), 0);

    // Asynchronous reset with three bits buffered
    data_out_ack = 1'b0;
    set_rate(3'd2);
    send(1'b1, 1'b0, st);
    send(1'b1, 1'b1, st);
    chk("pre_rst_in_ack", data_in_ack, 1'b0);
    chk("pre_rst_out_req", data_out_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_req", data_out_req, 1'b0);
    chk("rst_mid_out_i", data_out_i, 1'b0);
    chk("rst_mid_out_q", data_out_q, 1'b0);
    chk("rst_mid_in_ack", data_in_ack, 1'b0);
    idle(2);
    rst_n = 1'b1;
    #1;
    chk("rel_chg_in_ack", data_in_ack, 1'b0);
    idle(1);
    chk("rel_in_ack", data_in_ack, 1'b1);
    data_out_ack = 1'b1;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    send(1'b0, 1'b1, st); chk_int("fresh_stall", st, 0);
    send(1'b1, 1'b0, st); chk_int("fresh_stall", st, 0);
    send(1'b1, 1'b1, st); chk_int("fresh_stall", st, 0);
    send(1'b1, 1'b0, st); chk_int("fresh_stall", st, 0);
    idle(4);
    chk_int("fresh_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/zl_punct.md
# zl_punct

Puncturer for the rate-1/2 convolutional code stream. Consumes one (X, Y) coded-bit pair per input transfer from the convolutional encoder, deletes bits according to the selected DVB-S puncturing pattern and emits (I, Q) symbol pairs to the symbol mapper. It sits directly between the convolutional encoder and the mapper, with req/ack handshakes on both sides.

## Interface
- No parameters. Puncturing patterns are fixed in RTL.
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- rate  in  3  code rate select: 0=1/2, 1=2/3, 2=3/4, 3=5/6, 4=7/8, 5..7 treated as 1/2; quasi-static
- data_in_i  in  1  X bit (I-polynomial output of the encoder)
- data_in_q  in  1  Y bit (Q-polynomial output of the encoder)
- data_in_req  in  1  upstream pair valid
- data_in_ack  out  1  pair accepted; a transfer occurs when data_in_req && data_in_ack
- data_out_i  out  1  I symbol bit
- data_out_q  out  1  Q symbol bit
- data_out_req  out  1  symbol pair valid
- data_out_ack  in  1  downstream accepts; a transfer occurs when data_out_req && data_out_ack

## Operation
- Puncture patterns (X/Y, position 1 first): 1/2 1/1; 2/3 10/11; 3/4 101/110; 5/6 10101/11010; 7/8 1000101/1111010.
- phase counter: 0..P-1, where P = 1, 2, 3, 5, 7 for rates 1/2..7/8. Advances by 1 on each input transfer and wraps from P-1 to 0.
- On each input transfer, the kept bits are appended to a 4-bit FIFO, X before Y. Each transfer keeps 1 or 2 bits.
- Output: data_out_i = oldest bit, data_out_q = second-oldest bit. data_out_req = (count >= 2).
- Each output transfer removes 2 bits. Input and output transfers may occur in the same cycle; the pop is applied before the push.
- data_in_ack = (count <= 2) || (data_out_req && data_out_ack). The FIFO can therefore never overflow.
- Resulting mapping, 3/4: I = X1 Y2, Q = Y1 X3.
- Resulting mapping, 7/8: I = X1 Y2 Y4 Y6, Q = Y1 Y3 X5 X7.
- rate_q is a registered copy of rate.
- Rate-change cycle: when rate != rate_q, data_in_ack and data_out_req are forced to 0. At the next edge rate_q <= rate, count <= 0 and phase <= 0; buffered bits are discarded.
- Because rate_q resets to 0, a nonzero rate at reset release costs one rate-change cycle.

## Timing
- Reset values: data_out_req=0, data_out_i=0, data_out_q=0, data_in_ack=1 (when rate==0), count=0, phase=0, rate_q=0.
- Latency: the input transfer that completes a pair in cycle n makes data_out_req high in cycle n+1.
- Throughput, rate 1/2: one pair per cycle in and out with continuous acks. Steady state is count=2, with pop and push in the same cycle.
- Throughput, punctured rates: input ack is never lost when downstream is always ready.
- Combinational paths: data_out_ack -> data_in_ack and rate -> both req/ack. There are no combinational paths from data_in_req.
- Downstream stall: data_out_req stays high and data_out_i/q stay stable until ack. Input stops once count reaches 3 or 4.
- Reset mid-operation: all state clears immediately and asynchronously; partial pairs are lost.

## Configuration
- ZL_PUNCT_HIGH_RATES_EN defined: rates 5/6 and 7/8 (rate = 3, 4) are supported as above.
- ZL_PUNCT_HIGH_RATES_EN undefined: rates 3 and 4 behave as 1/2. The phase counter is 2 bits wide.

## Test plan
- Rate 1/2, pairs (1,0),(0,1),(1,1) with continuous acks -> outputs (1,0),(0,1),(1,1); first output req one cycle after the first input transfer.
- Rate 3/4, X=1,0,1 and Y=1,1,0 repeating (each position distinct via random data, checked against the model) -> I=X1,Y2 and Q=Y1,X3; 6 input pairs yield exactly 4 outputs.
- Rate 7/8, 14 random pairs -> 8 outputs matching I=X1 Y2 Y4 Y6 and Q=Y1 Y3 X5 X7 per period; the phase wraps to 0 after pair 7.
- Rate 2/3, data_out_ack held low 10 cycles -> data_in_ack drops once count=3; no bit lost or duplicated after ack resumes.
- Rate switched 2->4 with count=1 mid-period -> one cycle with req/ack low; the next input pair starts at phase 0 with an empty FIFO.
- rst_n asserted mid-stream with count=3 -> data_out_req=0 immediately; after release, behaviour matches a fresh start.
